// File: rtl/snes_controller_reader_pkg.sv
// Shared types and constants for the SNES controller reader: FSM states,
// button bit positions and frame geometry.
package snes_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        CLK_LOW,
        CLK_HIGH,
        DONE
    } snes_state_e;

    localparam int BTN_B      = 0;
    localparam int BTN_Y      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;
    localparam int BTN_A      = 8;
    localparam int BTN_X      = 9;
    localparam int BTN_L      = 10;
    localparam int BTN_R      = 11;

    // Latch (2 halves) plus 16 clock pulses (2 halves each)
    localparam int FRAME_HALVES = 34;
    localparam int NUM_BITS     = 16;

endpackage

// File: rtl/snes_controller_reader_if.sv
// Pin-level bundle between the controller reader and the SNES pad:
// the reader is the master, the pad (or its model) the slave.
interface snes_controller_reader_if;

    logic        serial_data;
    logic        snes_clk;
    logic        data_latch;
    logic [15:0] buttons;
    logic        buttons_valid;

    modport master (
        input  serial_data,
        output snes_clk,
        output data_latch,
        output buttons,
        output buttons_valid
    );

    modport slave (
        output serial_data,
        input  snes_clk,
        input  data_latch,
        input  buttons,
        input  buttons_valid
    );

endinterface

// File: rtl/snes_controller_reader_sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous input bit,
// with a selectable reset level so idle-high lines reset to their idle value.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic sync_out
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta     <= RESET_VAL;
            sync_out <= RESET_VAL;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/snes_controller_reader.sv
// Polls an SNES controller, shifts in its 16-bit active-low word and presents
// active-high buttons with a one-cycle strobe. Optional: SNES_DEBOUNCE_EN.
module snes_controller_reader
    import snes_pkg::*;
#(
    parameter int HALF_CYCLES = 300,
    parameter int POLL_CYCLES = 833333
) (
    input  logic                      clk,
    input  logic                      reset,
    snes_controller_reader_if.master  ctrl
);

    localparam int TIMER_W = $clog2(2 * HALF_CYCLES);
    localparam int POLL_W  = $clog2(POLL_CYCLES);

    localparam logic [TIMER_W-1:0] LATCH_LAST = TIMER_W'(2 * HALF_CYCLES - 1);
    localparam logic [TIMER_W-1:0] HALF_LAST  = TIMER_W'(HALF_CYCLES - 1);
    localparam logic [POLL_W-1:0]  POLL_LAST  = POLL_W'(POLL_CYCLES - 1);
    localparam logic [3:0]         LAST_BIT   = 4'(NUM_BITS - 1);

    snes_state_e         state;
    logic [TIMER_W-1:0]  timer;
    logic [POLL_W-1:0]   poll_cnt;
    logic [3:0]          bit_cnt;
    logic [15:0]         shift;
    logic                data_sync;
    logic                snes_clk_q;
    logic                latch_q;
    logic [15:0]         buttons_q;
    logic                valid_q;
`ifdef SNES_DEBOUNCE_EN
    logic [15:0]         prev_raw;
`endif

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (ctrl.serial_data),
        .sync_out (data_sync)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            poll_cnt <= '0;
        end else if (poll_cnt == POLL_LAST) begin
            poll_cnt <= '0;
        end else begin
            poll_cnt <= poll_cnt + POLL_W'(1);
        end
    end

    // Each bit is captured on the edge that drops snes_clk; the pad changes its
    // output on the rising edge, so the data has had a full half-period to settle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            timer      <= '0;
            bit_cnt    <= '0;
            shift      <= 16'hFFFF;
            snes_clk_q <= 1'b1;
            latch_q    <= 1'b0;
            buttons_q  <= 16'h0000;
            valid_q    <= 1'b0;
`ifdef SNES_DEBOUNCE_EN
            prev_raw   <= 16'hFFFF;
`endif
        end else begin
            valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (poll_cnt == '0) begin
                        state   <= LATCH;
                        latch_q <= 1'b1;
                        timer   <= '0;
                    end
                end
                LATCH: begin
                    if (timer == LATCH_LAST) begin
                        state      <= CLK_LOW;
                        latch_q    <= 1'b0;
                        snes_clk_q <= 1'b0;
                        timer      <= '0;
                        bit_cnt    <= '0;
                        shift[0]   <= data_sync;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                CLK_LOW: begin
                    if (timer == HALF_LAST) begin
                        state      <= CLK_HIGH;
                        snes_clk_q <= 1'b1;
                        timer      <= '0;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                CLK_HIGH: begin
                    if (timer == HALF_LAST) begin
                        timer <= '0;
                        if (bit_cnt != LAST_BIT) begin
                            state                  <= CLK_LOW;
                            snes_clk_q             <= 1'b0;
                            bit_cnt                <= bit_cnt + 4'd1;
                            shift[bit_cnt + 4'd1]  <= data_sync;
                        end else begin
                            state <= DONE;
`ifdef SNES_DEBOUNCE_EN
                            // Publish only a word seen twice in a row that actually changes the outputs
                            prev_raw <= shift;
                            if ((shift == prev_raw) && (~shift != buttons_q)) begin
                                buttons_q <= ~shift;
                                valid_q   <= 1'b1;
                            end
`else
                            buttons_q <= ~shift;
                            valid_q   <= 1'b1;
`endif
                        end
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign ctrl.snes_clk      = snes_clk_q;
    assign ctrl.data_latch    = latch_q;
    assign ctrl.buttons       = buttons_q;
    assign ctrl.buttons_valid = valid_q;

endmodule

// File: tb/tb_snes_controller_reader.sv
// Bench for snes_controller_reader: pad model driven by data_latch/snes_clk,
// frame observer and a word-level reference model of the button outputs.
module tb_snes_controller_reader;
    import snes_pkg::*;

    localparam int H         = 4;
    localparam int POLL      = 200;
    localparam int FRAME_LEN = FRAME_HALVES * H;

    logic clk;
    logic reset;
    int   cyc;
    int   errors;
    int   checks;

    logic [15:0] ctrl_word;
    int          ctrl_idx;

    logic [15:0] m_buttons;
    logic [15:0] m_prev;

    int          obs_wait;
    int          obs_t0;
    int          obs_latch_len;
    int          obs_nfall;
    int          obs_first_fall;
    int          obs_gap_bad;
    int          obs_valid_cnt;
    int          obs_valid_at;
    logic [15:0] obs_btn_strobe;
    logic [15:0] obs_btn_end;

    snes_controller_reader_if dif ();

    snes_controller_reader #(
        .HALF_CYCLES (H),
        .POLL_CYCLES (POLL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .ctrl  (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pad model: latch reloads bit 0, each rising snes_clk advances one bit.
    initial begin
        ctrl_idx        = 16;
        dif.serial_data = 1'b1;
        forever begin
            @(posedge dif.data_latch or posedge dif.snes_clk);
            if (dif.data_latch === 1'b1)
                ctrl_idx = 0;
            else if (ctrl_idx < 16)
                ctrl_idx++;
            dif.serial_data = (ctrl_idx < 16) ? ctrl_word[ctrl_idx] : 1'b1;
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic model_reset();
        m_buttons = 16'h0000;
        m_prev    = 16'hFFFF;
    endtask

    task automatic model_frame(input logic [15:0] raw, output bit strobe);
`ifdef SNES_DEBOUNCE_EN
        strobe = (raw == m_prev) && (~raw != m_buttons);
        m_prev = raw;
`else
        strobe = 1'b1;
`endif
        if (strobe) m_buttons = ~raw;
    endtask

    task automatic observe_frame(input logic [15:0] raw);
        logic prev_sclk;
        int   last_fall;
        ctrl_word      = raw;
        obs_wait       = 0;
        obs_latch_len  = 0;
        obs_nfall      = 0;
        obs_first_fall = -1;
        obs_gap_bad    = 0;
        obs_valid_cnt  = 0;
        obs_valid_at   = -1;
        obs_btn_strobe = 16'hxxxx;
        obs_btn_end    = 16'hxxxx;
        do begin
            @(negedge clk);
            obs_wait++;
        end while (dif.data_latch !== 1'b1 && obs_wait < POLL + 20);
        if (dif.data_latch !== 1'b1) begin
            errors++;
            checks++;
            $display("[TB] FAIL frame_start: data_latch=%b after %0d cycles, required 1", dif.data_latch, obs_wait);
            return;
        end
        obs_t0    = cyc;
        prev_sclk = 1'b1;
        last_fall = -1;
        for (int off = 0; off < FRAME_LEN + 4; off++) begin
            if (off > 0) @(negedge clk);
            if (dif.data_latch === 1'b1) obs_latch_len++;
            if (prev_sclk === 1'b1 && dif.snes_clk === 1'b0) begin
                if (obs_nfall == 0) obs_first_fall = off;
                else if (off - last_fall != 2 * H) obs_gap_bad++;
                last_fall = off;
                obs_nfall++;
            end
            prev_sclk = dif.snes_clk;
            if (dif.buttons_valid === 1'b1) begin
                obs_valid_cnt++;
                obs_valid_at   = off;
                obs_btn_strobe = dif.buttons;
            end
        end
        obs_btn_end = dif.buttons;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        ctrl_word = 16'hFEFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({dif.snes_clk, dif.data_latch, dif.buttons, dif.buttons_valid} !== {1'b1, 1'b0, 16'h0000, 1'b0}) begin
                errors++;
                $display("[TB] FAIL reset_values: clk=%b latch=%b buttons=%h valid=%b, required 1 0 0000 0",
                         dif.snes_clk, dif.data_latch, dif.buttons, dif.buttons_valid);
            end
        end
        model_reset();
        reset = 1'b0;
    endtask

    task automatic test_single_press();
        bit exp;
        observe_frame(16'hFEFF);
        model_frame(16'hFEFF, exp);
        checks++;
        if (obs_wait != 1) begin
            errors++;
            $display("[TB] FAIL first_frame_start: latch seen after %0d cycles, required 1", obs_wait);
        end
        checks++;
        if (obs_latch_len != 2 * H) begin
            errors++;
            $display("[TB] FAIL latch_len: %0d cycles, required %0d", obs_latch_len, 2 * H);
        end
        checks++;
        if (obs_nfall != 16) begin
            errors++;
            $display("[TB] FAIL fall_count: %0d, required 16", obs_nfall);
        end
        checks++;
        if (obs_first_fall != 2 * H) begin
            errors++;
            $display("[TB] FAIL first_fall: t0+%0d, required t0+%0d", obs_first_fall, 2 * H);
        end
        checks++;
        if (obs_gap_bad != 0) begin
            errors++;
            $display("[TB] FAIL fall_spacing: %0d bad gaps, required 0", obs_gap_bad);
        end
        checks++;
        if (obs_valid_cnt != (exp ? 1 : 0)) begin
            errors++;
            $display("[TB] FAIL single_strobe_count: %0d, required %0d", obs_valid_cnt, exp ? 1 : 0);
        end
        if (exp) begin
            checks++;
            if (obs_valid_at != FRAME_LEN) begin
                errors++;
                $display("[TB] FAIL strobe_time: t0+%0d, required t0+%0d", obs_valid_at, FRAME_LEN);
            end
            checks++;
            if (obs_btn_strobe !== m_buttons) begin
                errors++;
                $display("[TB] FAIL a_button: buttons=%h, required %h", obs_btn_strobe, m_buttons);
            end
        end
        checks++;
        if (obs_btn_end !== m_buttons) begin
            errors++;
            $display("[TB] FAIL single_hold: buttons=%h, required %h", obs_btn_end, m_buttons);
        end
    endtask

    task automatic test_no_controller();
        bit exp;
        int t_first;
        t_first = 0;
        for (int f = 0; f < 2; f++) begin
            observe_frame(16'hFFFF);
            model_frame(16'hFFFF, exp);
            if (f == 0) begin
                t_first = obs_t0;
            end else begin
                checks++;
                if (obs_t0 - t_first != POLL) begin
                    errors++;
                    $display("[TB] FAIL poll_period: %0d cycles between latches, required %0d", obs_t0 - t_first, POLL);
                end
            end
            checks++;
            if (obs_valid_cnt != (exp ? 1 : 0)) begin
                errors++;
                $display("[TB] FAIL idle_strobe_count: %0d, required %0d", obs_valid_cnt, exp ? 1 : 0);
            end
            checks++;
            if (obs_btn_end !== m_buttons) begin
                errors++;
                $display("[TB] FAIL idle_buttons: buttons=%h, required %h", obs_btn_end, m_buttons);
            end
        end
    endtask

    task automatic test_up_then_b();
        logic [15:0] words [2];
        bit exp;
        words[0] = 16'hFFEF;
        words[1] = 16'hFFFE;
        for (int f = 0; f < 2; f++) begin
            observe_frame(words[f]);
            model_frame(words[f], exp);
            checks++;
            if (obs_valid_cnt != (exp ? 1 : 0)) begin
                errors++;
                $display("[TB] FAIL dir_strobe_count: frame %0d %0d, required %0d", f, obs_valid_cnt, exp ? 1 : 0);
            end
            checks++;
            if (obs_btn_end !== m_buttons) begin
                errors++;
                $display("[TB] FAIL dir_buttons: frame %0d buttons=%h, required %h", f, obs_btn_end, m_buttons);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] word;
        bit exp;
        word = 16'hFFFF;
        for (int f = 0; f < 6; f++) begin
            if ($urandom_range(1, 0) == 0 || f == 0) word = 16'($urandom);
            observe_frame(word);
            model_frame(word, exp);
            checks++;
            if (obs_valid_cnt != (exp ? 1 : 0) || (exp && obs_valid_at != FRAME_LEN)) begin
                errors++;
                $display("[TB] FAIL rand_strobe: word %h count %0d at t0+%0d, required count %0d at t0+%0d",
                         word, obs_valid_cnt, obs_valid_at, exp ? 1 : 0, FRAME_LEN);
            end
            checks++;
            if (obs_btn_end !== m_buttons) begin
                errors++;
                $display("[TB] FAIL rand_buttons: word %h buttons=%h, required %h", word, obs_btn_end, m_buttons);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int   n;
        int   falls;
        int   strobes;
        logic prev_sclk;
        bit   exp;
        logic [15:0] word;
        ctrl_word = 16'h0000;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (dif.data_latch !== 1'b1 && n < POLL + 20);
        falls     = 0;
        prev_sclk = 1'b1;
        n         = 0;
        while (falls < 8 && n < FRAME_LEN + 8) begin
            @(negedge clk);
            n++;
            if (prev_sclk === 1'b1 && dif.snes_clk === 1'b0) falls++;
            prev_sclk = dif.snes_clk;
        end
        checks++;
        if (falls != 8) begin
            errors++;
            $display("[TB] FAIL reach_pulse7: saw %0d falls, required 8", falls);
        end
        reset   = 1'b1;
        strobes = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (dif.buttons_valid !== 1'b0) strobes++;
            if (i == 0) begin
                checks++;
                if ({dif.snes_clk, dif.data_latch, dif.buttons, dif.buttons_valid} !== {1'b1, 1'b0, 16'h0000, 1'b0}) begin
                    errors++;
                    $display("[TB] FAIL mid_reset_values: clk=%b latch=%b buttons=%h valid=%b, required 1 0 0000 0",
                             dif.snes_clk, dif.data_latch, dif.buttons, dif.buttons_valid);
                end
            end
        end
        checks++;
        if (strobes != 0) begin
            errors++;
            $display("[TB] FAIL mid_reset_strobe: %0d strobes, required 0", strobes);
        end
        model_reset();
        reset = 1'b0;
        word  = 16'($urandom);
        observe_frame(word);
        model_frame(word, exp);
        checks++;
        if (obs_wait != 1) begin
            errors++;
            $display("[TB] FAIL restart: latch seen after %0d cycles, required 1", obs_wait);
        end
        checks++;
        if (obs_btn_end !== m_buttons || obs_valid_cnt != (exp ? 1 : 0)) begin
            errors++;
            $display("[TB] FAIL restart_frame: buttons=%h strobes=%0d, required %h %0d",
                     obs_btn_end, obs_valid_cnt, m_buttons, exp ? 1 : 0);
        end
    endtask

`ifdef SNES_DEBOUNCE_EN
    task automatic test_debounce();
        bit exp;
        int total;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        model_reset();
        reset = 1'b0;
        total = 0;
        for (int f = 0; f < 4; f++) begin
            observe_frame((f % 2 == 0) ? 16'hFFFE : 16'hFFFF);
            model_frame((f % 2 == 0) ? 16'hFFFE : 16'hFFFF, exp);
            total += obs_valid_cnt;
        end
        checks++;
        if (total != 0 || obs_btn_end !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL bounce_hold: strobes=%0d buttons=%h, required 0 0000", total, obs_btn_end);
        end
        total = 0;
        for (int f = 0; f < 3; f++) begin
            observe_frame(16'hFFFE);
            model_frame(16'hFFFE, exp);
            total += obs_valid_cnt;
            checks++;
            if (obs_valid_cnt != (exp ? 1 : 0) || obs_btn_end !== m_buttons) begin
                errors++;
                $display("[TB] FAIL stable_frame: frame %0d strobes=%0d buttons=%h, required %0d %h",
                         f, obs_valid_cnt, obs_btn_end, exp ? 1 : 0, m_buttons);
            end
        end
        checks++;
        if (total != 1 || obs_btn_end !== 16'h0001) begin
            errors++;
            $display("[TB] FAIL stable_total: strobes=%0d buttons=%h, required 1 0001", total, obs_btn_end);
        end
    endtask
`endif

    initial begin
        errors    = 0;
        checks    = 0;
        reset     = 1'b1;
        ctrl_word = 16'hFFFF;
        model_reset();
        test_reset();
        test_single_press();
        test_no_controller();
        test_up_then_b();
        test_random();
        test_reset_mid_frame();
`ifdef SNES_DEBOUNCE_EN
        test_debounce();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
